n64_button_events: RTL and testbench

Downstream consumer of the N64 serial poller's 32-bit `button_data` word. It compares each new poll result against the previous one and turns button transitions into press/release event words. Events are queued in a small first-word-fall-through FIFO, so software or the APB front end can read every transition without polling at the controller rate. It also holds the latest analog stick position.

---
 rtl/n64_button_events.sv | 90 +++++++++
 tb/tb_n64_button_events.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/n64_button_events.sv
// Turns N64 poll results into press/release event words queued in a small FWFT FIFO,
// and keeps the most recent analog stick position.
module n64_button_events #(
  parameter int          DEPTH       = 8,
  parameter logic [15:0] BUTTON_MASK = 16'hFFFF
) (
  input  logic                     PCLK,
  input  logic                     PRESERN,
  input  logic [31:0]              button_data,
  input  logic                     sample_valid,
  input  logic                     clear,
  input  logic                     pop,
  output logic [31:0]              event_data,
  output logic                     event_valid,
  output logic [$clog2(DEPTH):0]   event_count,
  output logic                     overflow,
  output logic [15:0]              stick_xy
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   L_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   L_CNT1   = (AW+1)'(1);
  localparam logic [AW-1:0] L_PTR1   = AW'(1);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [15:0]   r_prev_btn;
  logic [15:0]   r_stick;
  logic          r_overflow;

  logic [15:0]   w_cur;
  logic [15:0]   w_press;
  logic [15:0]   w_release;
  logic          w_pop_ok;
  logic          w_push_req;
  logic          w_push_ok;
  logic          w_push_drop;

  assign w_cur       = button_data[31:16] & BUTTON_MASK;
  assign w_press     = w_cur & ~r_prev_btn;
  assign w_release   = ~w_cur & r_prev_btn;
  assign w_pop_ok    = pop && (r_count != '0);
  assign w_push_req  = sample_valid && ((w_press | w_release) != 16'h0);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept the push.
  assign w_push_ok   = w_push_req && ((r_count < L_FULL) || w_pop_ok);
  assign w_push_drop = w_push_req && !w_push_ok;

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_prev_btn <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_stick    <= '0;
    end else if (clear) begin
      r_prev_btn <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (sample_valid) begin
        r_stick    <= button_data[15:0];
        r_prev_btn <= w_cur;
      end
      if (w_push_drop) r_overflow <= 1'b1;
      if (w_push_ok)   r_wptr <= r_wptr + L_PTR1;
      if (w_pop_ok)    r_rptr <= r_rptr + L_PTR1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + L_CNT1;
        2'b01:   r_count <= r_count - L_CNT1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (!clear && w_push_ok) r_mem[r_wptr] <= {w_press, w_release};
  end

  assign event_valid = (r_count != '0);
  assign event_data  = event_valid ? r_mem[r_rptr] : 32'h0;
  assign event_count = r_count;
  assign overflow    = r_overflow;
  assign stick_xy    = r_stick;

endmodule

// File: tb/tb_n64_button_events.sv
// Directed bench for n64_button_events: a reference queue of expected events is filled
// as samples are driven and drained/compared as the DUT presents them.
module tb_n64_button_events;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          PCLK = 1'b0;
  logic          PRESERN;
  logic [31:0]   button_data;
  logic          sample_valid;
  logic          clear;
  logic          pop;
  logic [31:0]   event_data,  event_data2;
  logic          event_valid, event_valid2;
  logic [CW-1:0] event_count, event_count2;
  logic          overflow,    overflow2;
  logic [15:0]   stick_xy,    stick_xy2;

  int          compareCount = 0;
  int          failCount    = 0;
  logic [31:0] expQ[$];
  logic [15:0] mPrev;
  logic [15:0] mStick;
  logic        mOvf;

  n64_button_events #(.DEPTH(DEPTH), .BUTTON_MASK(16'hFFFF)) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .button_data(button_data),
    .sample_valid(sample_valid), .clear(clear), .pop(pop),
    .event_data(event_data), .event_valid(event_valid), .event_count(event_count),
    .overflow(overflow), .stick_xy(stick_xy)
  );

  n64_button_events #(.DEPTH(DEPTH), .BUTTON_MASK(16'h7FFF)) dutMasked (
    .PCLK(PCLK), .PRESERN(PRESERN), .button_data(button_data),
    .sample_valid(sample_valid), .clear(clear), .pop(pop),
    .event_data(event_data2), .event_valid(event_valid2), .event_count(event_count2),
    .overflow(overflow2), .stick_xy(stick_xy2)
  );

  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ":count"},    32'(event_count), 32'(expQ.size()));
    checkOutput({tag, ":valid"},    32'(event_valid), (expQ.size() != 0) ? 32'd1 : 32'd0);
    checkOutput({tag, ":data"},     event_data,       (expQ.size() != 0) ? expQ[0] : 32'h0);
    checkOutput({tag, ":overflow"}, 32'(overflow),    32'(mOvf));
    checkOutput({tag, ":stick"},    32'(stick_xy),    32'(mStick));
  endtask

  task automatic resetModel();
    expQ.delete();
    mPrev  = '0;
    mStick = '0;
    mOvf   = 1'b0;
  endtask

  // Drive one cycle of inputs at the falling edge, update the model, then release the
  // strobes 1 ns after the rising edge so outputs can be checked right away.
  task automatic applyStimulus(input logic [31:0] data, input logic sv, input logic clr, input logic pp);
    logic [15:0] cur, prs, rel;
    bit          popOk, pushOk;
    @(negedge PCLK);
    button_data  = data;
    sample_valid = sv;
    clear        = clr;
    pop          = pp;
    pushOk       = 0;
    if (clr) begin
      expQ.delete();
      mPrev = '0;
      mOvf  = 1'b0;
    end else begin
      popOk = pp && (expQ.size() != 0);
      if (popOk) checkOutput("popHead", event_data, expQ[0]);
      if (sv) begin
        cur    = data[31:16];
        prs    = cur & ~mPrev;
        rel    = ~cur & mPrev;
        mStick = data[15:0];
        mPrev  = cur;
        if ((prs | rel) != 16'h0) begin
          if (expQ.size() < DEPTH || popOk) pushOk = 1;
          else mOvf = 1'b1;
        end
      end
      if (popOk)  void'(expQ.pop_front());
      if (pushOk) expQ.push_back({prs, rel});
    end
    @(posedge PCLK);
    #1;
    sample_valid = 1'b0;
    clear        = 1'b0;
    pop          = 1'b0;
  endtask

  initial begin
    PRESERN      = 1'b0;
    button_data  = '0;
    sample_valid = 1'b0;
    clear        = 1'b0;
    pop          = 1'b0;
    resetModel();
    repeat (2) @(negedge PCLK);
    checkAll("reset");
    PRESERN = 1'b1;

    applyStimulus(32'h8000_1234, 1, 0, 0);
    checkAll("first");
    checkOutput("firstData",  event_data,        32'h8000_0000);
    checkOutput("firstStick", 32'(stick_xy),    32'h0000_1234);
    checkOutput("firstCount", 32'(event_count), 32'd1);
    applyStimulus(32'h4000_0000, 1, 0, 0);
    checkOutput("secondCount", 32'(event_count), 32'd2);
    applyStimulus(32'h4000_0000, 1, 0, 0);
    checkOutput("repeatCount", 32'(event_count), 32'd2);
    applyStimulus(32'h0, 0, 0, 1);
    checkOutput("secondData", event_data, 32'h4000_8000);
    checkAll("pop1");
    applyStimulus(32'h0, 0, 0, 1);
    checkAll("pop2");

    // Overflow: nine distinct samples into an eight-entry FIFO
    applyStimulus(32'h0, 0, 1, 0);
    checkAll("clear1");
    for (int i = 0; i < 9; i++) begin
      applyStimulus({16'(1 << i), 16'(i)}, 1, 0, 0);
      checkAll("fill");
    end
    checkOutput("fullCount",    32'(event_count), 32'd8);
    checkOutput("fullOverflow", 32'(overflow),    32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) checkOutput("eighthEvent", event_data, 32'h0080_0040);
      applyStimulus(32'h0, 0, 0, 1);
      checkAll("drain");
    end
    applyStimulus(32'h0000_0000, 1, 0, 0);
    checkOutput("afterDrop", event_data, 32'h0000_0100);
    checkOutput("stickyOvf", 32'(overflow), 32'd1);
    applyStimulus(32'h0, 0, 0, 1);
    checkAll("afterDropPop");

    // Full FIFO with simultaneous pop and push
    applyStimulus(32'h0, 0, 1, 0);
    for (int i = 0; i < 8; i++) applyStimulus({16'(1 << i), 16'h0}, 1, 0, 0);
    applyStimulus(32'h0000_0000, 1, 0, 1);
    checkOutput("pushPopCount", 32'(event_count), 32'd8);
    checkOutput("pushPopOvf",   32'(overflow),    32'd0);
    checkAll("pushPop");
    for (int i = 0; i < 8; i++) begin
      if (i == 7) checkOutput("lastEvent", event_data, 32'h0000_0080);
      applyStimulus(32'h0, 0, 0, 1);
      checkAll("drain2");
    end

    // Clear overrides a same-cycle sample and pop
    applyStimulus(32'h8000_00AB, 1, 0, 0);
    applyStimulus(32'h4000_5555, 1, 1, 1);
    checkOutput("clrCount", 32'(event_count), 32'd0);
    checkOutput("clrOvf",   32'(overflow),    32'd0);
    checkOutput("clrStick", 32'(stick_xy),    32'h0000_00AB);
    applyStimulus(32'h8000_0000, 1, 0, 0);
    checkOutput("clrRepress", event_data, 32'h8000_0000);
    checkAll("clrRepress");

    // Masked instance ignores bit 31 but still tracks the stick
    applyStimulus(32'h0, 0, 1, 0);
    applyStimulus(32'h8000_00AA, 1, 0, 0);
    applyStimulus(32'h0000_00BB, 1, 0, 0);
    applyStimulus(32'h8000_00CC, 1, 0, 0);
    checkAll("maskMain");
    checkOutput("maskCount", 32'(event_count2), 32'd0);
    checkOutput("maskValid", 32'(event_valid2), 32'd0);
    checkOutput("maskData",  event_data2,       32'h0);
    checkOutput("maskOvf",   32'(overflow2),    32'd0);
    checkOutput("maskStick", 32'(stick_xy2),    32'h0000_00CC);

    // Pop on empty changes nothing
    applyStimulus(32'h0, 0, 1, 0);
    checkAll("emptyBefore");
    applyStimulus(32'h0, 0, 0, 1);
    checkAll("popEmpty");

    // Asynchronous reset in the middle of a cycle
    applyStimulus(32'h0001_0777, 1, 0, 0);
    applyStimulus(32'h0002_0777, 1, 0, 0);
    @(negedge PCLK);
    #2;
    PRESERN = 1'b0;
    resetModel();
    #1;
    checkAll("asyncReset");
    checkOutput("asyncStick2", 32'(stick_xy2), 32'h0);
    @(negedge PCLK);
    PRESERN = 1'b1;
    applyStimulus(32'h0001_0000, 1, 0, 0);
    checkAll("postReset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
